adc_seq_capture: RTL

- Parametrised successor to the single-sequence LTC2308 capture engine.
- Drives the LTC2308 SPI pins (CONVST, SCK, SDI, SDO) through a programmable channel sequence of 1..NUM_CH slots, each with its own 6-bit config word.
- Writes tagged 32-bit result words into the capture RAM, either in single-shot mode (N samples) or in continuous ring-buffer mode.
- Sits between the JTAG-visible control registers and the dual-port capture RAM.

---
 rtl/adc_seq_capture.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/adc_seq_capture.sv
// rtl/adc_seq_capture.sv - LTC2308 multi-slot sequencer writing tagged results to capture RAM
module adc_seq_capture #(
  parameter int NUM_CH     = 8,
  parameter int ADDR_W     = 12,
  parameter int SCK_HALF   = 4,
  parameter int CONV_PULSE = 4,
  parameter int CONV_WAIT  = 264
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic                adc_convst,
  output logic                adc_sck,
  output logic                adc_sdi,
  input  logic                adc_sdo,
  output logic [ADDR_W-1:0]   adc_ram_addr,
  output logic                adc_ram_we,
  output logic [31:0]         adc_ram_wr_data,
  input  logic [NUM_CH*6-1:0] slot_config,
  input  logic [3:0]          num_slots,
  input  logic [ADDR_W:0]     num_samples,
  input  logic                continuous,
  input  logic                start,
  input  logic                abort,
  output logic                busy,
  output logic                done
);

  localparam logic [15:0]     PULSE_LAST = 16'(CONV_PULSE - 1);
  localparam logic [15:0]     WAIT_LAST  = 16'(CONV_WAIT - 1);
  localparam logic [15:0]     HALF_LAST  = 16'(SCK_HALF - 1);
  localparam logic [3:0]      SLOT_MAX   = 4'(NUM_CH - 1);
  localparam logic [ADDR_W:0] ONE        = (ADDR_W+1)'(1);

  typedef enum logic [2:0] {S_IDLE, S_PULSE, S_WAIT, S_SHIFT, S_WRITE} state_t;
  state_t state, state_next;

  logic [15:0]         cnt;
  logic [15:0]         div_cnt;
  logic [4:0]          phase;
  logic [NUM_CH*6-1:0] cfg_lat;
  logic [3:0]          ns_lat;
  logic [ADDR_W:0]     samples_lat;
  logic [ADDR_W:0]     wcnt;
  logic                cont_lat;
  logic                abort_lat;
  logic                prime;
  logic [3:0]          cur_slot;
  logic [3:0]          prev_slot;
  logic [15:0]         tag;
  logic [11:0]         result;
  logic [5:0]          cfg_sr;
  logic [5:0]          cfg_cur;
  logic                half_end;
  logic                sck_rise;
  logic                sck_fall;
  logic                shift_end;
  logic                last_word;

  assign half_end  = (div_cnt == HALF_LAST);
  assign sck_rise  = (state == S_SHIFT) && !phase[0] && (div_cnt == 16'd0);
  assign sck_fall  = (state == S_SHIFT) && !phase[0] && half_end;
  assign shift_end = (state == S_SHIFT) && (phase == 5'd23) && half_end;
  assign last_word = !prime && !cont_lat && (wcnt == samples_lat - ONE);

  always_comb begin
    cfg_cur = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (cur_slot == 4'(k)) cfg_cur = cfg_lat[6*k +: 6];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start && !abort) state_next = S_PULSE;
      S_PULSE: if (cnt == PULSE_LAST) state_next = S_WAIT;
      S_WAIT:  if (cnt == WAIT_LAST) state_next = S_SHIFT;
      S_SHIFT: if (shift_end) state_next = S_WRITE;
      S_WRITE: state_next = (abort_lat || abort || last_word) ? S_IDLE : S_PULSE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    adc_convst      = (state == S_PULSE);
    adc_sck         = (state == S_SHIFT) && !phase[0];
    busy            = (state != S_IDLE);
    adc_ram_we      = (state == S_WRITE) && !prime;
    adc_ram_wr_data = adc_ram_we ? {tag, prev_slot, result} : 32'd0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt          <= '0;
      div_cnt      <= '0;
      phase        <= '0;
      cfg_lat      <= '0;
      ns_lat       <= '0;
      samples_lat  <= '0;
      wcnt         <= '0;
      cont_lat     <= 1'b0;
      abort_lat    <= 1'b0;
      prime        <= 1'b0;
      cur_slot     <= '0;
      prev_slot    <= '0;
      tag          <= '0;
      result       <= '0;
      cfg_sr       <= '0;
      adc_sdi      <= 1'b0;
      adc_ram_addr <= '0;
      done         <= 1'b0;
    end else begin
      done <= (state != S_IDLE) && (state_next == S_IDLE);
      cnt  <= (state != state_next) ? 16'd0 : cnt + 16'd1;

      if (state == S_SHIFT) begin
        div_cnt <= half_end ? 16'd0 : div_cnt + 16'd1;
        if (half_end) phase <= phase + 5'd1;
      end else begin
        div_cnt <= '0;
        phase   <= '0;
      end

      if (state == S_IDLE && start && !abort) begin
        cfg_lat      <= slot_config;
        ns_lat       <= (num_slots > SLOT_MAX) ? SLOT_MAX : num_slots;
        samples_lat  <= (num_samples == '0) ? ONE : num_samples;
        cont_lat     <= continuous;
        abort_lat    <= 1'b0;
        prime        <= 1'b1;
        wcnt         <= '0;
        cur_slot     <= '0;
        prev_slot    <= '0;
        tag          <= '0;
        adc_ram_addr <= '0;
      end

      if (state != S_IDLE && abort) abort_lat <= 1'b1;

      // SDI leads SCK: MSB is presented before the first rise, later bits change on each fall
      if (state == S_PULSE && cnt == PULSE_LAST) begin
        adc_sdi <= cfg_cur[5];
        cfg_sr  <= {cfg_cur[4:0], 1'b0};
      end
      if (sck_fall) begin
        adc_sdi <= cfg_sr[5];
        cfg_sr  <= {cfg_sr[4:0], 1'b0};
      end

      if (sck_rise) result <= {result[10:0], adc_sdo};

      if (state == S_WRITE) begin
        prev_slot <= cur_slot;
        cur_slot  <= (cur_slot == ns_lat) ? 4'd0 : cur_slot + 4'd1;
        prime     <= 1'b0;
        if (!prime) begin
          adc_ram_addr <= adc_ram_addr + 1'b1;
          tag          <= tag + 16'd1;
          wcnt         <= wcnt + ONE;
        end
      end
    end
  end

endmodule
